mpack_fifo: RTL and testbench
=============================

Name: mpack_fifo

Overview:
- Parametrised successor of the router's multi-input/single-output FIFO. Each write beat accepts up to N_IN lanes, compacted and stored in order; each pop reads one packed DATA_WIDTH word.
- Precision mode packs 1, 2 or 4 entries per pop, using the low DATA_WIDTH/P bits of each entry.
- Sits between the router scatter stage and a PE-row feeder.
- Supports replay: consumed entries are retained until committed, so a tile can be re-read for weight or activation reuse.

Parameters:
- DEPTH, 32, entries; power of two, at least 8.
- DATA_WIDTH, 8, entry and output width; divisible by 4.
- N_IN, 8, write lanes per beat; N_IN <= DEPTH.
- ADDR_WIDTH, $clog2(DEPTH), localparam; pointers are ADDR_WIDTH+1 bits (wrap bit).

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  asynchronous reset, active-low
- i_clear  in  1  synchronous flush: all pointers to 0
- i_write_en  in  1  write beat strobe
- i_valid  in  N_IN  per-lane valid; any pattern allowed
- i_data  in  N_IN*DATA_WIDTH  lane data, lane 0 in the LSBs
- i_p_mode  in  2  00: P=1, 01: P=2, 10: P=4, 11: reserved (treated as 00)
- i_pop_en  in  1  pop request
- i_rewind  in  1  read pointer returns to the commit base
- i_commit  in  1  base moves to the read pointer, freeing consumed entries
- o_data  out  DATA_WIDTH  packed output word
- o_pop_valid  out  1  o_data valid (one cycle after an accepted pop)
- o_wr_ack  out  1  registered: previous write beat was accepted
- o_empty  out  1  no unread entries (wr == rd)
- o_full  out  1  free space < N_IN
- o_count  out  ADDR_WIDTH+1  unread entries (wr - rd)

Behaviour:
- Pointers:
  - Three pointers: wr, rd and base, each ADDR_WIDTH+1 bits and wrapping modulo 2*DEPTH.
  - Storage index is pointer[ADDR_WIDTH-1:0].
  - used = wr - base; free = DEPTH - used; unread = wr - rd.
- Reset (async) and i_clear (sync) set wr = rd = base = 0 and o_data, o_pop_valid, o_wr_ack = 0. Storage contents are not reset.
- Priority: i_clear > i_rewind > i_commit > pop. Writes are independent of this chain except under i_clear, which drops any write in the same cycle.
- Write acceptance:
  - A beat is accepted iff i_write_en=1 and k = popcount(i_valid) satisfies k <= free.
  - Valid lanes are written in ascending lane order to wr, wr+1, ... wr+k-1, with wrap; then wr += k.
  - A rejected beat is dropped entirely, never partially written. k = 0 is a no-op.
  - o_wr_ack <= accepted && k > 0.
- Pop:
  - Accepted iff i_pop_en=1, unread > 0, and no i_clear or i_rewind that cycle.
  - n = min(P, unread). o_data[j*W +: W] = entry[rd+j][W-1:0] for j < n, where W = DATA_WIDTH/P. Unused upper slices are 0.
  - For n = 1 with P > 1, the full entry[rd] is output; this keeps the 4x4/2x2 tail convention of the previous generation.
  - rd += n. Next-cycle outputs: o_pop_valid = 1, o_data as above.
  - Otherwise o_pop_valid <= 0 and o_data <= 0.
  - Latency: 1 cycle from pop to data.
  - Entries written in cycle t are poppable from cycle t+1; unread is computed from registered wr.
- i_rewind: rd <= base. o_pop_valid <= 0.
- i_commit: base <= rd (the pre-update rd). A same-cycle pop advances rd, but the base captures the old rd.
- Concurrent write and commit: free is evaluated with the pre-commit base. This is conservative, and the freed space is seen next cycle.
- Status outputs are combinational from registered pointers: o_empty, o_full, o_count.
- rd never passes wr, and wr never passes base + DEPTH.

Optional Feature:
- Macro: MPACK_FIFO_ERR_EN.
- When defined, adds output o_err[1:0], sticky and cleared only by reset or i_clear.
  - o_err[0] sets on a rejected write beat with k > 0.
  - o_err[1] sets on i_pop_en while o_empty=1.
- When undefined, the port and logic are absent; rejected writes and empty pops are silent.

Decomposition:
- Package mpack_pkg holds:
  - p_mode_e enum (P_8X8, P_4X4, P_2X2)
  - function pack_factor(p_mode_e) returning 1, 2 or 4
  - function popcount
- One sub-module, mpack_compact: combinational lane compaction. From i_valid and i_data it produces k and compacted lanes 0..k-1.
- The FIFO core does the storage and pointers.

Test Plan:
- Compaction: DEPTH=32, N_IN=8, i_valid=8'b1010_0101, data lane i = 0x10+i → entries 0x10, 0x12, 0x15, 0x17; o_count=4; o_wr_ack=1.
- 2x2 packing: entries 0x03, 0x02, 0x01, 0x00, 0x03, mode 10 → pop1 o_data=8'b00_01_10_11; pop2 o_data=0x03 (tail, full entry); o_empty=1.
- Full: 4 beats of 8 valid lanes → used=32, o_full=1. A fifth beat is rejected and o_wr_ack=0. Pop 8, then commit → beat accepted.
- Wrap and replay: write 40 entries over time with commits; pop 3, rewind → same 3 values re-emitted. Commit, then rewind → nothing re-emitted.
- Simultaneous: pop with commit the same cycle → base = old rd. Rewind with pop → rewind wins and o_pop_valid=0 next cycle.
- Reset mid-operation: assert i_nrst=0 while o_pop_valid=1 → all outputs 0 immediately; o_empty=1 and o_count=0 after release.

Source files
------------

// File: rtl/mpack_pkg.sv
// mpack_pkg: shared types and helpers for the packing FIFO.
//   p_mode_e    : precision mode (entries packed per pop: 1, 2 or 4)
//   pack_factor : mode -> entries per pop
//   popcount    : number of set bits in a lane-valid vector (zero-extended to MaxLanes)
package mpack_pkg;

    typedef enum logic [1:0] {
        P_8X8 = 2'b00,
        P_4X4 = 2'b01,
        P_2X2 = 2'b10
    } p_mode_e;

    localparam int unsigned MaxLanes = 64;

    function automatic int unsigned pack_factor(input p_mode_e mode);
        case (mode)
            P_4X4:   return 2;
            P_2X2:   return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int unsigned popcount(input logic [MaxLanes-1:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < MaxLanes; i++) begin
            if (v[i]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/mpack_compact.sv
// mpack_compact: combinational lane compaction.
// Ports:
//   i_valid  per-lane valid
//   i_data   lane data, lane 0 in the LSBs
//   o_k      number of valid lanes
//   o_lanes  valid lanes packed into slots 0..k-1 in ascending lane order; unused slots 0
module mpack_compact
    import mpack_pkg::*;
#(
    parameter int unsigned N_IN       = 8,
    parameter int unsigned DATA_WIDTH = 8,
    localparam int unsigned KW        = $clog2(N_IN + 1)
) (
    input  logic [N_IN-1:0]            i_valid,
    input  logic [N_IN*DATA_WIDTH-1:0] i_data,
    output logic [KW-1:0]              o_k,
    output logic [N_IN*DATA_WIDTH-1:0] o_lanes
);

    always_comb begin
        int unsigned slot;
        slot    = 0;
        o_lanes = '0;
        o_k     = KW'(popcount(MaxLanes'(i_valid)));
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (i_valid[i]) begin
                o_lanes[slot*DATA_WIDTH +: DATA_WIDTH] = i_data[i*DATA_WIDTH +: DATA_WIDTH];
                slot++;
            end
        end
    end

endmodule

// File: rtl/mpack_fifo.sv
// mpack_fifo: multi-lane-in / packed-word-out FIFO with commit/rewind replay.
// Each write beat stores up to N_IN compacted lanes; each pop returns 1, 2 or 4 entries
// packed into one DATA_WIDTH word. Popped entries stay resident until committed.
// Ports:
//   i_clk, i_nrst (async, active-low), i_clear (sync flush)
//   i_write_en, i_valid, i_data   write beat
//   i_p_mode                      00:P=1 01:P=2 10:P=4 11:P=1
//   i_pop_en, i_rewind, i_commit  read side controls
//   o_data, o_pop_valid           registered pop result (1-cycle latency)
//   o_wr_ack                      registered write-accepted flag
//   o_empty, o_full, o_count      status from registered pointers
// Optional: define MPACK_FIFO_ERR_EN to add sticky o_err[1:0]
//   (bit 0: rejected non-empty write, bit 1: pop while empty).
module mpack_fifo
    import mpack_pkg::*;
#(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N_IN       = 8,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_clear,
    input  logic                       i_write_en,
    input  logic [N_IN-1:0]            i_valid,
    input  logic [N_IN*DATA_WIDTH-1:0] i_data,
    input  logic [1:0]                 i_p_mode,
    input  logic                       i_pop_en,
    input  logic                       i_rewind,
    input  logic                       i_commit,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic                       o_pop_valid,
    output logic                       o_wr_ack,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [ADDR_WIDTH:0]        o_count
`ifdef MPACK_FIFO_ERR_EN
    ,
    output logic [1:0]                 o_err
`endif
);

    localparam int unsigned PW = ADDR_WIDTH + 1;
    localparam int unsigned KW = $clog2(N_IN + 1);
    localparam int unsigned HW = DATA_WIDTH / 2;
    localparam int unsigned QW = DATA_WIDTH / 4;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d, base_q, base_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  pop_valid_q, pop_valid_d;
    logic                  wr_ack_q, wr_ack_d;

    logic [PW-1:0]              used, free, unread;
    logic [KW-1:0]              k;
    logic [N_IN*DATA_WIDTH-1:0] lanes;
    logic                       wr_accept, pop_accept;
    p_mode_e                    mode;
    int unsigned                pf, n;
    logic [DATA_WIDTH-1:0]      ent [4];
    logic [DATA_WIDTH-1:0]      packed_word;

    mpack_compact #(
        .N_IN       (N_IN),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_compact (
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_k     (k),
        .o_lanes (lanes)
    );

    // Modulo-2*DEPTH arithmetic keeps the wrap bit meaningful in all differences.
    assign used   = wr_q - base_q;
    assign free   = PW'(DEPTH) - used;
    assign unread = wr_q - rd_q;

    assign mode = (i_p_mode == 2'b11) ? P_8X8 : p_mode_e'(i_p_mode);
    assign pf   = pack_factor(mode);
    assign n    = (pf < 32'(unread)) ? pf : 32'(unread);

    // Free space uses the pre-commit base; space freed by a commit is seen next cycle.
    assign wr_accept  = i_write_en && !i_clear && (32'(k) <= 32'(free));
    assign pop_accept = i_pop_en && (unread != '0) && !i_clear && !i_rewind;

    always_comb begin
        for (int unsigned j = 0; j < 4; j++) begin
            ent[j] = mem_q[ADDR_WIDTH'(rd_q + PW'(j))];
        end
    end

    // A lone entry is always emitted whole, whatever the mode.
    always_comb begin
        packed_word = ent[0];
        if (n > 1) begin
            packed_word = '0;
            if (pf == 2) begin
                packed_word = {ent[1][HW-1:0], ent[0][HW-1:0]};
            end else begin
                for (int unsigned j = 0; j < 4; j++) begin
                    if (j < n) packed_word[j*QW +: QW] = ent[j][QW-1:0];
                end
            end
        end
    end

    always_comb begin
        wr_d        = wr_q;
        rd_d        = rd_q;
        base_d      = base_q;
        data_d      = '0;
        pop_valid_d = 1'b0;
        wr_ack_d    = 1'b0;
        if (i_clear) begin
            wr_d   = '0;
            rd_d   = '0;
            base_d = '0;
        end else begin
            if (wr_accept) begin
                wr_d     = wr_q + PW'(k);
                wr_ack_d = (k != '0);
            end
            if (i_rewind) begin
                rd_d = base_q;
            end else begin
                // Commit captures the pre-pop read pointer.
                if (i_commit) base_d = rd_q;
                if (pop_accept) begin
                    rd_d        = rd_q + PW'(n);
                    pop_valid_d = 1'b1;
                    data_d      = packed_word;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_q        <= '0;
            rd_q        <= '0;
            base_q      <= '0;
            data_q      <= '0;
            pop_valid_q <= 1'b0;
            wr_ack_q    <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            base_q      <= base_d;
            data_q      <= data_d;
            pop_valid_q <= pop_valid_d;
            wr_ack_q    <= wr_ack_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (i < 32'(k)) begin
                    mem_q[ADDR_WIDTH'(wr_q + PW'(i))] <= lanes[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign o_data      = data_q;
    assign o_pop_valid = pop_valid_q;
    assign o_wr_ack    = wr_ack_q;
    assign o_empty     = (wr_q == rd_q);
    assign o_full      = (free < PW'(N_IN));
    assign o_count     = unread;

`ifdef MPACK_FIFO_ERR_EN
    logic [1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (i_clear) begin
            err_d = '0;
        end else begin
            if (i_write_en && !wr_accept && (k != '0)) err_d[0] = 1'b1;
            if (i_pop_en && o_empty) err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) err_q <= '0;
        else         err_q <= err_d;
    end

    assign o_err = err_q;
`endif

endmodule

// File: tb/tb_mpack_fifo.sv
// tb_mpack_fifo: table-driven vectors plus directed multi-cycle sequences for mpack_fifo
// (DEPTH=32, DATA_WIDTH=8, N_IN=8).
module tb_mpack_fifo;

    logic        clk;
    logic        nrst;
    logic        clr, we, pop, rew, com;
    logic [7:0]  vld;
    logic [63:0] din;
    logic [1:0]  mode;
    logic [7:0]  dout;
    logic        pv, ack, emp, ful;
    logic [5:0]  cnt;

    int n_tests;
    int n_fail;

    mpack_fifo #(
        .DEPTH      (32),
        .DATA_WIDTH (8),
        .N_IN       (8)
    ) dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_clear     (clr),
        .i_write_en  (we),
        .i_valid     (vld),
        .i_data      (din),
        .i_p_mode    (mode),
        .i_pop_en    (pop),
        .i_rewind    (rew),
        .i_commit    (com),
        .o_data      (dout),
        .o_pop_valid (pv),
        .o_wr_ack    (ack),
        .o_empty     (emp),
        .o_full      (ful),
        .o_count     (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr, we;
        logic [7:0] vld;
        logic [1:0] mode;
        logic       pop, rew, com;
        logic       pv;
        logic [7:0] dat;
        logic       ack, emp, ful;
        logic [5:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic c, input logic w, input logic [7:0] v,
                                input logic [1:0] m, input logic p, input logic r,
                                input logic cm, input logic epv, input logic [7:0] ed,
                                input logic ea, input logic ee, input logic ef,
                                input logic [5:0] ec);
        vec_t t;
        t.clr = c;   t.we = w;   t.vld = v;  t.mode = m;
        t.pop = p;   t.rew = r;  t.com = cm;
        t.pv  = epv; t.dat = ed; t.ack = ea; t.emp = ee; t.ful = ef; t.cnt = ec;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        clr = 1'b0; we = 1'b0; vld = '0; mode = 2'b00;
        pop = 1'b0; rew = 1'b0; com = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int b);
        for (int i = 0; i < 8; i++) din[i*8 +: 8] = 8'(b * 8 + i);
    endtask

    task automatic do_pop(input logic [1:0] m, input logic [7:0] exp, input string name);
        idle();
        pop  = 1'b1;
        mode = m;
        tick();
        chk({name, ".pv"}, 64'(pv), 64'd1);
        chk({name, ".data"}, 64'(dout), 64'(exp));
    endtask

    vec_t tbl [19];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        din  = 64'h1716_1514_1312_1110;
        nrst = 1'b0;

        //      clr we vld    md pop rew com | pv dat   ack emp ful cnt
        tbl[0]  = mk(0, 1, 8'hA5, 0, 0, 0, 0,  0, 8'h00, 1, 0, 0, 4);  // compaction
        tbl[1]  = mk(0, 0, 8'h00, 0, 1, 0, 0,  1, 8'h10, 0, 0, 0, 3);
        tbl[2]  = mk(0, 0, 8'h00, 1, 1, 0, 0,  1, 8'h52, 0, 0, 0, 1);  // P=2 halves
        tbl[3]  = mk(0, 0, 8'h00, 1, 1, 0, 0,  1, 8'h17, 0, 1, 0, 0);  // P=2 tail, whole
        tbl[4]  = mk(0, 0, 8'h00, 0, 1, 0, 0,  0, 8'h00, 0, 1, 0, 0);  // pop on empty
        tbl[5]  = mk(0, 0, 8'h00, 0, 0, 1, 0,  0, 8'h00, 0, 0, 0, 4);  // rewind to base 0
        tbl[6]  = mk(0, 0, 8'h00, 3, 1, 0, 0,  1, 8'h10, 0, 0, 0, 3);  // reserved -> P=1
        tbl[7]  = mk(0, 0, 8'h00, 0, 1, 0, 1,  1, 8'h12, 0, 0, 0, 2);  // commit+pop: base=1
        tbl[8]  = mk(0, 0, 8'h00, 0, 0, 1, 0,  0, 8'h00, 0, 0, 0, 3);  // back to 1
        tbl[9]  = mk(0, 0, 8'h00, 2, 1, 0, 0,  1, 8'h36, 0, 1, 0, 0);  // P=4, n=3
        tbl[10] = mk(0, 0, 8'h00, 0, 0, 1, 0,  0, 8'h00, 0, 0, 0, 3);
        tbl[11] = mk(0, 0, 8'h00, 0, 1, 1, 0,  0, 8'h00, 0, 0, 0, 3);  // rewind beats pop
        tbl[12] = mk(0, 0, 8'h00, 0, 1, 0, 0,  1, 8'h12, 0, 0, 0, 2);
        tbl[13] = mk(0, 0, 8'h00, 0, 0, 0, 1,  0, 8'h00, 0, 0, 0, 2);  // commit: base=2
        tbl[14] = mk(0, 0, 8'h00, 0, 0, 1, 0,  0, 8'h00, 0, 0, 0, 2);  // rewind to 2
        tbl[15] = mk(1, 1, 8'hA5, 0, 1, 0, 0,  0, 8'h00, 0, 1, 0, 0);  // clear drops all
        tbl[16] = mk(0, 1, 8'h00, 0, 0, 0, 0,  0, 8'h00, 0, 1, 0, 0);  // k=0 no-op
        tbl[17] = mk(0, 1, 8'h80, 0, 0, 0, 0,  0, 8'h00, 1, 0, 0, 1);
        tbl[18] = mk(0, 0, 8'h00, 2, 1, 0, 0,  1, 8'h17, 0, 1, 0, 0);  // P=4 lone entry

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        tick();
        chk("rst.pv", 64'(pv), 64'd0);
        chk("rst.data", 64'(dout), 64'd0);
        chk("rst.ack", 64'(ack), 64'd0);
        chk("rst.empty", 64'(emp), 64'd1);
        chk("rst.full", 64'(ful), 64'd0);
        chk("rst.count", 64'(cnt), 64'd0);

        for (int i = 0; i < 19; i++) begin
            clr = tbl[i].clr; we = tbl[i].we; vld = tbl[i].vld; mode = tbl[i].mode;
            pop = tbl[i].pop; rew = tbl[i].rew; com = tbl[i].com;
            tick();
            chk($sformatf("vec%0d.pv", i), 64'(pv), 64'(tbl[i].pv));
            chk($sformatf("vec%0d.data", i), 64'(dout), 64'(tbl[i].dat));
            chk($sformatf("vec%0d.ack", i), 64'(ack), 64'(tbl[i].ack));
            chk($sformatf("vec%0d.empty", i), 64'(emp), 64'(tbl[i].emp));
            chk($sformatf("vec%0d.full", i), 64'(ful), 64'(tbl[i].ful));
            chk($sformatf("vec%0d.count", i), 64'(cnt), 64'(tbl[i].cnt));
        end

        // P=4 packing: 03,02,01,00 -> 00_01_10_11, then tail 03 whole
        idle();
        clr = 1'b1;
        tick();
        idle();
        we  = 1'b1;
        vld = 8'h1F;
        din = 64'h0000_0003_0001_0203;
        tick();
        do_pop(2'b10, 8'h1B, "p4.pop1");
        do_pop(2'b10, 8'h03, "p4.pop2");
        chk("p4.empty", 64'(emp), 64'd1);

        // Fill, reject, free by commit
        idle();
        clr = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            idle();
            we  = 1'b1;
            vld = 8'hFF;
            set_beat(b);
            tick();
            chk($sformatf("fill%0d.ack", b), 64'(ack), 64'd1);
            if (b == 2) chk("fill2.full", 64'(ful), 64'd0);
        end
        chk("full.count", 64'(cnt), 64'd32);
        chk("full.full", 64'(ful), 64'd1);
        idle();
        we  = 1'b1;
        vld = 8'hFF;
        set_beat(4);
        tick();
        chk("reject.ack", 64'(ack), 64'd0);
        chk("reject.count", 64'(cnt), 64'd32);
        for (int i = 0; i < 8; i++) do_pop(2'b00, 8'(i), $sformatf("drain%0d", i));
        chk("drain.full", 64'(ful), 64'd1);
        // Write alongside commit still sees the old base
        idle();
        we  = 1'b1;
        vld = 8'hFF;
        com = 1'b1;
        tick();
        chk("wrcommit.ack", 64'(ack), 64'd0);
        chk("wrcommit.full", 64'(ful), 64'd0);
        idle();
        we  = 1'b1;
        vld = 8'hFF;
        tick();
        chk("postcommit.ack", 64'(ack), 64'd1);
        chk("postcommit.count", 64'(cnt), 64'd32);
        chk("postcommit.full", 64'(ful), 64'd1);

        // Replay after rewind, then commit removes replay
        for (int i = 8; i < 11; i++) do_pop(2'b00, 8'(i), $sformatf("play%0d", i));
        idle();
        rew = 1'b1;
        tick();
        chk("rewind.pv", 64'(pv), 64'd0);
        chk("rewind.count", 64'(cnt), 64'd32);
        for (int i = 8; i < 11; i++) do_pop(2'b00, 8'(i), $sformatf("replay%0d", i));
        idle();
        com = 1'b1;
        tick();
        idle();
        rew = 1'b1;
        tick();
        chk("commitrew.count", 64'(cnt), 64'd29);
        // Remaining entries, including the wrapped ones
        for (int i = 11; i < 40; i++) do_pop(2'b00, 8'(i), $sformatf("wrap%0d", i));
        chk("wrap.empty", 64'(emp), 64'd1);

        // Async reset while a pop result is being presented
        idle();
        clr = 1'b1;
        tick();
        idle();
        we  = 1'b1;
        vld = 8'h03;
        din = 64'h0000_0000_0000_5AA5;
        tick();
        do_pop(2'b00, 8'hA5, "prereset");
        idle();
        nrst = 1'b0;
        #1;
        chk("arst.pv", 64'(pv), 64'd0);
        chk("arst.data", 64'(dout), 64'd0);
        chk("arst.ack", 64'(ack), 64'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        tick();
        chk("arst.empty", 64'(emp), 64'd1);
        chk("arst.count", 64'(cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
